// File: rtl/huffman_sample_sequencer_pkg.sv
// Shared MP3 decoder types and constants for the Huffman-to-requantizer sample path.
package mp3_pkg;

   localparam int GRANULE_LEN = 576;
   localparam int MAX_PAIRS   = 288;
   localparam int SAMPLE_W    = 16;
   localparam int POS_W       = 10;

   typedef logic signed [SAMPLE_W-1:0] sample_t;
   typedef logic [POS_W-1:0]           pos_t;

   typedef enum logic [2:0] {IDLE, BIG, COUNT1, ZERO, DONE} seq_state_t;

   localparam pos_t POS_END = pos_t'(GRANULE_LEN);

   function automatic logic [8:0] clamp_pairs(input logic [8:0] bv);
      return (bv > 9'(MAX_PAIRS)) ? 9'(MAX_PAIRS) : bv;
   endfunction

endpackage

// File: rtl/huffman_sample_sequencer_if.sv
// Huffman-decoder input and requantizer sample stream of the sample sequencer.
interface huffman_sample_sequencer_if;
   import mp3_pkg::*;

   logic          si_valid;
   logic [8:0]    big_values;
   sample_t [1:0] pair_in;
   logic          pair_valid;
   logic          pair_ready;
   sample_t [3:0] quad_in;
   logic          quad_valid;
   logic          quad_ready;
   logic          count1_done;
   sample_t       x_out;
   pos_t          is_pos;
   logic          dout_v;
   logic          busy;
   logic          granule_done;

   // master: the sequencer itself; slave: the decoder/requantizer environment around it
   modport master (
      input  si_valid, big_values, pair_in, pair_valid, quad_in, quad_valid, count1_done,
      output pair_ready, quad_ready, x_out, is_pos, dout_v, busy, granule_done
   );

   modport slave (
      output si_valid, big_values, pair_in, pair_valid, quad_in, quad_valid, count1_done,
      input  pair_ready, quad_ready, x_out, is_pos, dout_v, busy, granule_done
   );

endinterface

// File: rtl/huffman_sample_sequencer_sample_shift_buffer.sv
// Four-deep element store: loads a pair or a (possibly truncated) quad, pops one element per cycle.
module sample_shift_buffer
   import mp3_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic          load_quad,
   input  sample_t [3:0] load_data,
   input  pos_t          room,
   output sample_t       head,
   output logic [2:0]    cnt
);

   sample_t [3:0] mem;
   logic [2:0]    load_n;

   // Loads only happen when the buffer is empty after this cycle's pop, so a load simply overwrites.
   always_comb begin
      load_n = 3'd2;
      if (load_quad) begin
         load_n = (room < pos_t'(4)) ? room[2:0] : 3'd4;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem <= '0;
         cnt <= '0;
      end else if (load) begin
         mem <= load_data;
         cnt <= load_n;
      end else if (cnt != '0) begin
         mem <= {{SAMPLE_W{1'b0}}, mem[3:1]};
         cnt <= cnt - 3'd1;
      end
   end

   assign head = mem[0];

endmodule

// File: rtl/huffman_sample_sequencer.sv
// Serialises big_values pairs, count1 quads and rzero fill into one sample per cycle for the requantizer.
//   state  | meaning
//   IDLE   | waiting for si_valid
//   BIG    | accepting big_values pairs
//   COUNT1 | accepting count1 quads until count1_done or position 576
//   ZERO   | emitting zeros up to index 575
//   DONE   | one-cycle granule_done, back to IDLE
module huffman_sample_sequencer
   import mp3_pkg::*;
(
   input logic                        clk,
   input logic                        rst_n,
   huffman_sample_sequencer_if.master hs
);

   seq_state_t    state, state_nxt;
   logic [8:0]    pairs_left;
   pos_t          pos_cnt, pos_next, room;
   logic          c1_seen, c1_any;
   logic [2:0]    buf_cnt;
   sample_t       buf_head;
   sample_t [3:0] load_data;
   logic          cnt_low, pair_rdy, quad_rdy, pair_hs, quad_hs;
   logic          emit_zero, emit;
   sample_t       x_out_r;
   pos_t          is_pos_r;
   logic          dout_v_r;

   always_comb begin
      cnt_low   = buf_cnt <= 3'd1;
      pair_rdy  = (state == BIG) && cnt_low && (pairs_left != '0);
      quad_rdy  = (state == COUNT1) && cnt_low &&
                  ((11'(pos_cnt) + 11'(buf_cnt)) < 11'(GRANULE_LEN));
      pair_hs   = pair_rdy && hs.pair_valid;
      quad_hs   = quad_rdy && hs.quad_valid;
      emit_zero = (state == ZERO) && (buf_cnt == '0) && (pos_cnt < POS_END);
      emit      = (buf_cnt != '0) || emit_zero;
      pos_next  = pos_cnt + pos_t'(emit);
      room      = POS_END - pos_next;
      c1_any    = c1_seen || hs.count1_done;
      load_data = hs.quad_in;
      if (pair_hs) begin
         load_data      = '0;
         load_data[1:0] = hs.pair_in;
      end
   end

   // BIG hands over while the last pair element is still pending so quads follow without a gap.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (hs.si_valid) state_nxt = (hs.big_values != '0) ? BIG : COUNT1;
         BIG:     if (pairs_left == '0) state_nxt = COUNT1;
         COUNT1:  if (pos_cnt == POS_END) state_nxt = DONE;
                  else if (c1_any && !quad_hs && cnt_low) state_nxt = ZERO;
         ZERO:    if (pos_cnt == POS_END) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         pairs_left <= '0;
         pos_cnt    <= '0;
         c1_seen    <= 1'b0;
         x_out_r    <= '0;
         is_pos_r   <= '0;
         dout_v_r   <= 1'b0;
      end else begin
         state   <= state_nxt;
         pos_cnt <= (state == IDLE) ? '0 : pos_next;
         if (state == IDLE) begin
            c1_seen <= 1'b0;
            if (hs.si_valid) pairs_left <= clamp_pairs(hs.big_values);
         end else begin
            if (pair_hs) pairs_left <= pairs_left - 9'd1;
            if ((state == BIG || state == COUNT1) && hs.count1_done) c1_seen <= 1'b1;
         end
         dout_v_r <= emit;
         if (emit) begin
            x_out_r  <= (buf_cnt != '0) ? buf_head : '0;
            is_pos_r <= pos_cnt;
         end
      end
   end

   sample_shift_buffer u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (pair_hs || quad_hs),
      .load_quad (quad_hs),
      .load_data (load_data),
      .room      (room),
      .head      (buf_head),
      .cnt       (buf_cnt)
   );

   assign hs.pair_ready   = pair_rdy;
   assign hs.quad_ready   = quad_rdy;
   assign hs.x_out        = x_out_r;
   assign hs.is_pos       = is_pos_r;
   assign hs.dout_v       = dout_v_r;
   assign hs.busy         = (state != IDLE) && (state != DONE);
   assign hs.granule_done = (state == DONE);

endmodule
